// File: rtl/ray_scheduler_pkg.sv
// Shared definitions for the ray scheduler: FSM encoding, colour constants,
// ray_dir field layout and a saturating-increment helper.
package ray_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

    // ray_dir = {x[9:0], y[9:0], z[7:0]}
    localparam int DIR_Z_LSB = 0;
    localparam int DIR_Z_W   = 8;
    localparam int DIR_Y_LSB = 8;
    localparam int DIR_Y_W   = 10;
    localparam int DIR_X_LSB = 18;
    localparam int DIR_X_W   = 10;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ray_scheduler_pixel_counter.sv
// Raster-order x/y pixel counter with wrap, last-pixel flag and the linear
// frame-buffer address y*H_RES+x.
module pixel_counter
    import ray_scheduler_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [18:0] addr,
    output logic        last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == 10'(H_RES - 1)) begin
                x <= '0;
                y <= (y == 10'(V_RES - 1)) ? 10'd0 : y + 10'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    assign last = (x == 10'(H_RES - 1)) && (y == 10'(V_RES - 1));

    // Full 19-bit product so any frame up to 2^19 pixels addresses cleanly.
    assign addr = (19'(y) * 19'(H_RES)) + 19'(x);

endmodule

// File: rtl/ray_scheduler.sv
// Ray scheduler: walks every pixel of the frame, issues one ray per pixel to
// the tracer and writes the returned colour to the frame buffer.
// Optional per-ray watchdog enabled by defining WATCHDOG_EN.
module ray_scheduler
    import ray_scheduler_pkg::*;
#(
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter logic [27:0] CAM_INIT = 28'h0,
    parameter logic [7:0]  DIR_Z    = 8'd64,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [27:0] ray_init,
    output logic [27:0] ray_dir,
    output logic        ray_valid,
    input  logic        ray_ready,
    input  logic        tracer_ret,
    input  logic [11:0] tracer_dout,
    input  logic        collision_sig,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] collision_cnt
);

    state_t      state;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [18:0] pix_addr;
    logic        pix_last;
    logic        pix_clear;
    logic        pix_advance;

`ifdef WATCHDOG_EN
    logic [15:0] watchdog;
`endif

    assign pix_clear   = (state == ST_IDLE) && start;
    assign pix_advance = (state == ST_WRITE) && !abort;

    pixel_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_pixel_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (pix_clear),
        .advance (pix_advance),
        .x       (pix_x),
        .y       (pix_y),
        .addr    (pix_addr),
        .last    (pix_last)
    );

    assign ray_init = CAM_INIT;
    assign ray_dir[DIR_X_LSB +: DIR_X_W] = pix_x;
    assign ray_dir[DIR_Y_LSB +: DIR_Y_W] = pix_y;
    assign ray_dir[DIR_Z_LSB +: DIR_Z_W] = DIR_Z;
    assign fb_addr = pix_addr;

    // Counters only move in WRITE, so ray_dir stays put while a ray is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            ray_valid     <= 1'b0;
            fb_we         <= 1'b0;
            fb_data       <= BLACK;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            collision_cnt <= '0;
`ifdef WATCHDOG_EN
            watchdog      <= '0;
`endif
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                ray_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            collision_cnt <= '0;
                            state         <= ST_ISSUE;
                            ray_valid     <= 1'b1;
                            busy          <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        if (ray_ready) begin
                            state     <= ST_WAIT;
                            ray_valid <= 1'b0;
`ifdef WATCHDOG_EN
                            watchdog  <= '0;
`endif
                        end
                    end
                    ST_WAIT: begin
`ifdef WATCHDOG_EN
                        watchdog <= watchdog + 16'd1;
`endif
                        if (tracer_ret) begin
                            fb_data <= tracer_dout;
                            if (collision_sig) begin
                                collision_cnt <= sat_inc(collision_cnt);
                            end
                            state <= ST_WRITE;
                            fb_we <= 1'b1;
                        end
`ifdef WATCHDOG_EN
                        // Timed-out rays are painted black and never counted as hits.
                        else if ((watchdog + 16'd1) == 16'(TIMEOUT)) begin
                            fb_data <= BLACK;
                            state   <= ST_WRITE;
                            fb_we   <= 1'b1;
                        end
`endif
                    end
                    ST_WRITE: begin
                        if (pix_last) begin
                            state      <= ST_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            ray_valid <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        ray_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ray_scheduler.md
RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 Parameter H_RES, default 640, horizontal pixel count.
REQ-002 Parameter V_RES, default 480, vertical pixel count.
REQ-003 Parameter CAM_INIT, default 28'h0, ray origin driven on ray_init.
REQ-004 Parameter DIR_Z, default 8'd64, constant depth component of every ray direction.
REQ-005 Parameter TIMEOUT, default 255, watchdog cycles per ray (used only with WATCHDOG_EN).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  frame start request, sampled in IDLE only.
REQ-009 abort  in  1  abandon the current frame.
REQ-010 ray_init  out  28  ray origin, constant CAM_INIT.
REQ-011 ray_dir  out  28  {x[9:0], y[9:0], DIR_Z[7:0]} of the current pixel.
REQ-012 ray_valid  out  1  ray request to the tracer.
REQ-013 ray_ready  in  1  tracer accepts the ray.
REQ-014 tracer_ret  in  1  tracer result valid.
REQ-015 tracer_dout  in  12  shaded colour.
REQ-016 collision_sig  in  1  collision flag, qualified by tracer_ret.
REQ-017 fb_we  out  1  frame-buffer write strobe.
REQ-018 fb_addr  out  19  pixel address y*H_RES+x.
REQ-019 fb_data  out  12  pixel colour.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 frame_done  out  1  one-cycle completion pulse.
REQ-022 collision_cnt  out  16  saturating count of collided rays in the current frame.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-024 IDLE: start=1 clears x, y and collision_cnt, then goes to ISSUE.
REQ-025 ISSUE: ray_valid=1 with ray_dir held stable; ray_valid&ray_ready goes to WAIT.
REQ-026 WAIT: tracer_ret=1 latches tracer_dout into fb_data, increments collision_cnt if collision_sig=1 (saturating at 16'hFFFF), then goes to WRITE.
REQ-027 WRITE: fb_we=1 for exactly one cycle with fb_addr of the current pixel.
REQ-028 WRITE, pixel advance: x increments; at x=H_RES-1, x wraps to 0 and y increments.
REQ-029 WRITE, exit: the last pixel (H_RES-1, V_RES-1) goes to DONE; any other pixel goes to ISSUE.
REQ-030 DONE: frame_done=1 for one cycle, then IDLE.
REQ-031 tracer_ret in any state other than WAIT is ignored.
REQ-032 start outside IDLE is ignored.
REQ-033 abort=1 in any non-IDLE state goes to IDLE next cycle: no fb_we, no frame_done; collision_cnt is held.
REQ-034 abort takes priority over every other transition in the same cycle.
REQ-035 Minimum per-pixel latency: 3 cycles (ISSUE, WAIT, WRITE) when ray_ready and tracer_ret are both high on their first cycle.
REQ-036 fb_addr is computed at 19 bits without overflow for H_RES*V_RES <= 2^19.

Reset
REQ-037 rst=1: state=IDLE, x=y=0, ray_valid=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0, collision_cnt=0, watchdog=0.
REQ-038 Reset asserted mid-frame takes effect immediately; the frame is not resumed after release.

Configuration
REQ-039 With WATCHDOG_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle.
REQ-040 With WATCHDOG_EN defined: a count of TIMEOUT without tracer_ret forces fb_data=12'h000 and goes to WRITE.
REQ-041 With WATCHDOG_EN defined: a timed-out ray does not count as a collision.
REQ-042 Without WATCHDOG_EN: no counter logic exists and WAIT waits indefinitely.

Structure
REQ-043 The shared package holds: FSM state encoding, colour constants BLACK=12'h000 and WHITE=12'hFFF, and the ray_dir field offsets.
REQ-044 One sub-module, pixel_counter, holds the x/y counters with wrap and the address generation.

Verification
REQ-045 H_RES=4, V_RES=2, ray_ready=1, tracer_ret returned 1 cycle after issue -> 8 fb_we pulses at addresses 0..7, then frame_done, busy low after.
REQ-046 ray_ready held low 5 cycles -> ray_valid and ray_dir stable for 5 cycles, no state change.
REQ-047 collision_sig=1 on 3 of 8 returns -> collision_cnt=3 at frame_done; the next start clears it to 0.
REQ-048 abort asserted in WAIT on pixel 5 -> IDLE next cycle, no fb_we at address 5, no frame_done.
REQ-049 WATCHDOG_EN, TIMEOUT=10, tracer_ret withheld -> fb_data=12'h000 written after 10 WAIT cycles, frame continues.
REQ-050 rst pulsed mid-WRITE -> all outputs at reset values in the same cycle; start=1 restarts from address 0.
